puf_response_ctrl: RTL and testbench

PUF_RESPONSE_CTRL -- requirements
Module: puf_response_ctrl

---
 rtl/puf_ctrl_pkg.sv | 24 ++
 rtl/puf_settle_timer.sv | 29 ++
 rtl/puf_response_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_puf_response_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF response controller.
package puf_ctrl_pkg;

    localparam int unsigned BASE_W     = 6;
    localparam int unsigned CHAL_W     = 8;
    localparam int unsigned VOTE_COUNT = 3;

    // Low mux bit selects which oscillator of the pair is measured.
    localparam logic MUX_SEL_A = 1'b0;
    localparam logic MUX_SEL_B = 1'b1;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CLR_A  = 4'd1,
        RUN_A  = 4'd2,
        CAP_A  = 4'd3,
        CLR_B  = 4'd4,
        RUN_B  = 4'd5,
        CAP_B  = 4'd6,
        DECIDE = 4'd7,
        FINISH = 4'd8
    } state_t;

endpackage

// File: rtl/puf_settle_timer.sv
// Down-counter that holds the PUF counter reset for SETTLE_CYC cycles.
module puf_settle_timer #(
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired_c
);

    localparam int unsigned TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [TW-1:0] cnt_q;

    // Loaded on entry so that the final hold cycle sees zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= TW'(SETTLE_CYC - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/puf_response_ctrl.sv
// Sequences paired ring-oscillator measurements into a RESP_BITS response word.
// Optional build macro: PUF_MAJORITY_VOTE_EN (three measurement pairs per bit, majority vote).
module puf_response_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned RESP_BITS  = 16,
    parameter int unsigned CNT_W      = 33,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 start,
    input  logic [5:0]           base_chal,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    output logic [7:0]           puf_chal,
    output logic                 puf_en,
    output logic                 puf_rst,
    input  logic                 puf_done,
    input  logic [CNT_W-1:0]     puf_count
);

    localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       i_q, i_d;
    logic [RESP_BITS-1:0]   shadow_q, shadow_d;
    logic [BASE_W-1:0]      base_q, base_d;
    logic [CNT_W-1:0]       cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]       cnt_b_q, cnt_b_d;

    logic                   busy_d, resp_valid_d, puf_en_d, puf_rst_d;
    logic [RESP_BITS-1:0]   resp_d;
    logic [CHAL_W-1:0]      puf_chal_d;

    logic                   cmp_c, bit_c, commit_c;
    logic                   settle_load_c, settle_dec_c, settle_expired_c;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam logic [1:0] VOTE_LAST = 2'(VOTE_COUNT - 1);
    logic [1:0] pass_q, pass_d;
    logic [1:0] tally_q, tally_d;
`endif

    assign cmp_c = (cnt_a_q > cnt_b_q);

    puf_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk       (clk),
        .rst       (RST),
        .load      (settle_load_c),
        .dec       (settle_dec_c),
        .expired_c (settle_expired_c)
    );

    // Next state, datapath updates, and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        shadow_d = shadow_q;
        base_d   = base_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        bit_c    = cmp_c;
        commit_c = 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
        pass_d   = pass_q;
        tally_d  = tally_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_chal;
                    i_d      = '0;
                    shadow_d = '0;
                    state_d  = CLR_A;
`ifdef PUF_MAJORITY_VOTE_EN
                    pass_d   = '0;
                    tally_d  = '0;
`endif
                end
            end
            CLR_A:  if (settle_expired_c) state_d = RUN_A;
            RUN_A:  if (puf_done) state_d = CAP_A;
            CAP_A: begin
                cnt_a_d = puf_count;
                state_d = CLR_B;
            end
            CLR_B:  if (settle_expired_c) state_d = RUN_B;
            RUN_B:  if (puf_done) state_d = CAP_B;
            CAP_B: begin
                cnt_b_d = puf_count;
                state_d = DECIDE;
            end
            DECIDE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                if (pass_q != VOTE_LAST) begin
                    commit_c = 1'b0;
                    pass_d   = pass_q + 2'd1;
                    tally_d  = tally_q + 2'(cmp_c);
                    state_d  = CLR_A;
                end else begin
                    bit_c    = (tally_q + 2'(cmp_c)) >= 2'd2;
                    pass_d   = '0;
                    tally_d  = '0;
                end
`endif
                if (commit_c) begin
                    shadow_d[i_q] = bit_c;
                    if (i_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        i_d     = i_q + IDX_W'(1);
                        state_d = CLR_A;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with state_q.
        busy_d       = (state_d != IDLE) && (state_d != FINISH);
        resp_valid_d = (state_d == FINISH);
        resp_d       = (state_d == FINISH) ? shadow_d : resp;
        puf_en_d     = (state_d == RUN_A) || (state_d == RUN_B);
        puf_rst_d    = (state_d == IDLE) || (state_d == CLR_A) || (state_d == CLR_B) ||
                       (state_d == DECIDE) || (state_d == FINISH);
        case (state_d)
            CLR_A, RUN_A, CAP_A: puf_chal_d = {i_d[0], MUX_SEL_A, base_d};
            CLR_B, RUN_B, CAP_B: puf_chal_d = {i_d[0], MUX_SEL_B, base_d};
            default:             puf_chal_d = '0;
        endcase

        settle_load_c = ((state_d == CLR_A) && (state_q != CLR_A)) ||
                        ((state_d == CLR_B) && (state_q != CLR_B));
        settle_dec_c  = (state_q == CLR_A) || (state_q == CLR_B);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            i_q        <= '0;
            shadow_q   <= '0;
            base_q     <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            busy       <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
            puf_chal   <= '0;
            puf_en     <= 1'b0;
            puf_rst    <= 1'b1;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            shadow_q   <= shadow_d;
            base_q     <= base_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            busy       <= busy_d;
            resp       <= resp_d;
            resp_valid <= resp_valid_d;
            puf_chal   <= puf_chal_d;
            puf_en     <= puf_en_d;
            puf_rst    <= puf_rst_d;
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    always_ff @(posedge clk) begin
        if (RST) begin
            pass_q  <= '0;
            tally_q <= '0;
        end else begin
            pass_q  <= pass_d;
            tally_q <= tally_d;
        end
    end
`endif

endmodule

// File: tb/tb_puf_response_ctrl.sv
// Directed self-checking bench for puf_response_ctrl with a behavioural PUF model.
`timescale 1ns/1ps
module tb_puf_response_ctrl;

    localparam int unsigned RESP_BITS  = 4;
    localparam int unsigned CNT_W      = 33;
    localparam int unsigned SETTLE_CYC = 4;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int unsigned VOTES = 3;
`else
    localparam int unsigned VOTES = 1;
`endif
    localparam int unsigned RISES_PER_TXN = RESP_BITS * 2 * VOTES;
    localparam int BUDGET = 2000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [5:0]           base_chal;
    logic                 busy;
    logic [RESP_BITS-1:0] resp;
    logic                 resp_valid;
    logic [7:0]           puf_chal;
    logic                 puf_en;
    logic                 puf_rst;
    logic                 puf_done = 1'b0;
    logic [CNT_W-1:0]     puf_count = '0;

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int run_cnt = 0;
    int pair_idx = 0;
    int n_rises = 0;
    int n_bad = 0;
    int n_valid = 0;
    int rst_run = 0;
    logic prev_en = 1'b0;
    logic [7:0] chal_a [2];
    logic [7:0] chal_b [2];

    always #5 clk = ~clk;

    puf_response_ctrl #(
        .RESP_BITS  (RESP_BITS),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk        (clk),
        .RST        (rst),
        .start      (start),
        .base_chal  (base_chal),
        .busy       (busy),
        .resp       (resp),
        .resp_valid (resp_valid),
        .puf_chal   (puf_chal),
        .puf_en     (puf_en),
        .puf_rst    (puf_rst),
        .puf_done   (puf_done),
        .puf_count  (puf_count)
    );

    function automatic logic [CNT_W-1:0] model_count(input int m, input logic odd,
                                                      input logic b, input int pair);
        case (m)
            0:       return b ? (odd ? 33'd95 : 33'd90) : (odd ? 33'd80 : 33'd100);
            1:       return 33'h1_0000_0000;
            2:       return b ? 33'h0_FFFF_FFFF : 33'h1_0000_0000;
            4:       return b ? 33'd100 : (((pair % 3) == 1) ? 33'd10 : 33'd200);
            default: return '0;
        endcase
    endfunction

    // PUF model (done after 3 enabled cycles; mode 3 never finishes) plus monitors.
    always @(negedge clk) begin
        puf_count = model_count(mode, puf_chal[7], puf_chal[6], pair_idx);
        if (puf_en && (mode != 3)) begin
            run_cnt  = run_cnt + 1;
            puf_done = (run_cnt == 3);
        end else begin
            run_cnt  = 0;
            puf_done = 1'b0;
        end
        if (prev_en && !puf_en && puf_chal[6]) pair_idx = pair_idx + 1;
        if (puf_en && !prev_en) begin
            n_rises = n_rises + 1;
            if ((rst_run < SETTLE_CYC) || (puf_chal[6] && (rst_run != SETTLE_CYC)))
                n_bad = n_bad + 1;
        end
        rst_run = (puf_rst && !puf_en) ? rst_run + 1 : 0;
        prev_en = puf_en;
        if (puf_en) begin
            if (puf_chal[6]) chal_b[puf_chal[7]] = puf_chal;
            else             chal_a[puf_chal[7]] = puf_chal;
        end
        if (resp_valid) n_valid = n_valid + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            tick();
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_txn(input string tag, input logic [5:0] base, input int m,
                           input logic [RESP_BITS-1:0] exp);
        bit ok;
        int r0, v0;
        mode      = m;
        pair_idx  = 0;
        r0        = n_rises;
        v0        = n_valid;
        base_chal = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_chal = 6'h3F;
        check({tag, "_busy_rise"}, busy, 1);
        wait_valid(ok);
        check({tag, "_done"}, ok, 1);
        check({tag, "_resp"}, resp, exp);
        check({tag, "_busy_fin"}, busy, 0);
        tick();
        check({tag, "_valid_pulse"}, resp_valid, 0);
        check({tag, "_resp_hold"}, resp, exp);
        check({tag, "_rises"}, n_rises - r0, RISES_PER_TXN);
        check({tag, "_valid_cnt"}, n_valid - v0, 1);
    endtask

    initial begin
        bit ok;
        int r0, v0;

        // Reset with start held high alongside it.
        rst       = 1'b1;
        start     = 1'b1;
        base_chal = 6'h3F;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_resp", resp, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_en", puf_en, 0);
        check("rst_puf_rst", puf_rst, 1);
        check("rst_chal", puf_chal, 0);
        tick();
        check("rst_start_ignored", busy, 0);

        // Alternating counts: 100>90 for even bits, 80<95 for odd bits.
        run_txn("alt", 6'h2A, 0, 4'b0101);
        check("chal_a_i0", chal_a[0], 8'h2A);
        check("chal_b_i0", chal_b[0], 8'h6A);
        check("chal_a_i1", chal_a[1], 8'hAA);
        check("chal_b_i1", chal_b[1], 8'hEA);

        // Equal counts with bit 32 set, then bit 32 against all-ones low bits.
        run_txn("equal", 6'h15, 1, 4'b0000);
        run_txn("msb", 6'h01, 2, 4'b1111);

        // Start pulsed mid-measurement must be ignored.
        mode      = 0;
        r0        = n_rises;
        v0        = n_valid;
        base_chal = 6'h2A;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_poke_busy", busy, 1);
        check("busy_poke_resp_held", resp, 4'b1111);
        wait_valid(ok);
        check("busy_poke_done", ok, 1);
        check("busy_poke_resp", resp, 4'b0101);
        tick();
        check("busy_poke_rises", n_rises - r0, RISES_PER_TXN);
        check("busy_poke_valid_cnt", n_valid - v0, 1);

        // Start in the FINISH cycle is ignored, then accepted once IDLE.
        mode  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(ok);
        check("fin_done", ok, 1);
        check("fin_resp", resp, 4'b0000);
        mode  = 2;
        start = 1'b1;
        tick();
        check("fin_start_ignored", busy, 0);
        check("fin_valid_drop", resp_valid, 0);
        tick();
        start = 1'b0;
        check("idle_start_accepted", busy, 1);
        wait_valid(ok);
        check("idle_done", ok, 1);
        check("idle_resp", resp, 4'b1111);
        tick();

        // Reset during RUN_B.
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ok    = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            if (puf_en && puf_chal[6]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("runb_reached", ok, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("runb_rst_busy", busy, 0);
        check("runb_rst_en", puf_en, 0);
        check("runb_rst_puf_rst", puf_rst, 1);
        check("runb_rst_resp", resp, 0);
        check("runb_rst_valid", resp_valid, 0);
        check("runb_rst_chal", puf_chal, 0);
        tick();
        check("runb_rst_stays_idle", busy, 0);

        // Stuck puf_done holds the block in RUN until reset.
        mode  = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 60; k++) tick();
        check("stuck_busy", busy, 1);
        check("stuck_en", puf_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stuck_rst_busy", busy, 0);
        check("stuck_rst_en", puf_en, 0);

        run_txn("recover", 6'h2A, 0, 4'b0101);
`ifdef PUF_MAJORITY_VOTE_EN
        // Comparisons 1,0,1 per bit: majority gives 1.
        run_txn("vote", 6'h07, 4, 4'b1111);
`endif
        check("settle_hold", n_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
